// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the shared-bus drive arbiter.
// State encoding, default sizes, keeper/driver strength selection.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  localparam int N_REQ_DEF    = 4;
  localparam int W_DEF        = 8;
  localparam int HOLD_MAX_DEF = 16;

  typedef enum logic {
    STR_PULL   = 1'b0,
    STR_STRONG = 1'b1
  } drv_str_e;

  // Owner drives hard, the keeper only pulls so any driver overrides it.
  localparam drv_str_e DRV_STR  = STR_STRONG;
  localparam drv_str_e KEEP_STR = STR_PULL;
  localparam logic     KEEP_VAL = 1'b0;

endpackage

// File: rtl/bus_drive_arb_rr_pick.sv
// Combinational round-robin search: first set req strictly after ptr.
// Ports: req (requests), ptr (previous owner), win (one-hot winner).
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win
);

  logic          found;
  logic [PW-1:0] idx;

  // k runs 1..N so the previous owner is the very last candidate.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_drive_arb.sv
// Round-robin arbiter owning a shared tri-state bus, with contention flag.
// Ports: clk, rst_n, req/last/wdata per requester, grant, bus, busy, contention.
module bus_drive_arb
  import bus_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int W        = W_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   last,
  input  logic [N_REQ*W-1:0] wdata,
  output logic [N_REQ-1:0]   grant,
  inout  wire  [W-1:0]       bus,
  output logic               busy,
  output logic               contention
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] HOLD_END = 8'(HOLD_MAX - 1);

  arb_state_e    state, state_nx;
  logic [PW-1:0] ptr, ptr_nx;
  logic [7:0]    hold, hold_nx;
  logic          settle, settle_nx;
  logic          rdy;

  logic [N_REQ-1:0] win;
  logic [PW-1:0]    win_idx;
  logic             any_req;
  logic             own_req;
  logic             own_last;
  logic             hold_end;
  logic             drv_en;
  logic             mismatch;
  logic [W-1:0]     slot [N_REQ];
  logic [W-1:0]     drv_val;

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .win (win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) win_idx = PW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      slot[i] = wdata[i*W +: W];
    end
  end

  // ptr doubles as the current owner while in DRIVE.
  assign drv_val  = slot[ptr];
  assign any_req  = |req;
  assign own_req  = req[ptr];
  assign own_last = last[ptr];
  assign hold_end = (hold == HOLD_END);
  assign drv_en   = (state == DRIVE);

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    hold_nx   = hold;
    settle_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (rdy && any_req) begin
          state_nx = DRIVE;
          ptr_nx   = win_idx;
          hold_nx  = '0;
        end
      end
      DRIVE: begin
        hold_nx = hold + 8'd1;
        if (own_last || !own_req || hold_end) begin
          state_nx = TURN;
        end
      end
      TURN: begin
        if (any_req) begin
          state_nx  = DRIVE;
          ptr_nx    = win_idx;
          hold_nx   = '0;
          settle_nx = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // rdy holds off the first grant until the second edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= PW'(N_REQ - 1);
      hold   <= '0;
      settle <= 1'b0;
      rdy    <= 1'b0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      hold   <= hold_nx;
      settle <= settle_nx;
      rdy    <= 1'b1;
    end
  end

  // First DRIVE cycle after a turnaround may still see the old driver.
  assign mismatch = drv_en && !settle && (bus != drv_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contention <= 1'b0;
    end else if (mismatch) begin
      contention <= 1'b1;
    end
  end

  always_comb begin
    grant = '0;
    if (state == DRIVE) grant[ptr] = 1'b1;
  end

  assign busy = (state != IDLE);

  generate
    if (DRV_STR == STR_STRONG) begin : g_drv_strong
      assign (strong1, strong0) bus = drv_en ? drv_val : {W{1'bz}};
    end else begin : g_drv_pull
      assign (pull1, pull0) bus = drv_en ? drv_val : {W{1'bz}};
    end
    if (KEEP_STR == STR_PULL) begin : g_keep_pull
      assign (pull0, pull1) bus = {W{KEEP_VAL}};
    end else begin : g_keep_weak
      assign (weak0, weak1) bus = {W{KEEP_VAL}};
    end
  endgenerate

endmodule

// File: doc/bus_drive_arb.md
BUS_DRIVE_ARB -- requirements
Module: bus_drive_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter W, default 8, shared bus width.
REQ-003 Parameter HOLD_MAX, default 16, maximum consecutive DRIVE cycles per grant (1..255).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  N_REQ  per-requester drive request; level-sensitive.
REQ-007 last  input  N_REQ  per-requester end-of-transfer flag; qualified only for the current owner.
REQ-008 wdata  input  N_REQ*W  flattened per-requester drive data; slice i = requester i.
REQ-009 grant  output  N_REQ  one-hot current owner; all zero when not in DRIVE.
REQ-010 bus  inout  W  shared wired bus.
REQ-011 busy  output  1  high in DRIVE and TURN.
REQ-012 contention  output  1  sticky: driven value differs from sampled bus value.

Function
REQ-013 States are IDLE, DRIVE and TURN, and the state register holds exactly one of them.
REQ-014 IDLE: if any req is set, the next cycle enters DRIVE with grant set to the round-robin winner.
REQ-015 Round-robin winner is the first set req strictly after the previous owner, searching upward and wrapping at N_REQ-1 to 0.
REQ-016 After reset, the search starts at index 0.
REQ-017 DRIVE: bus is driven from wdata[owner] with strength (strong1, strong0).
REQ-018 Outside DRIVE, the bus driver is high-impedance and the bus is held by a (pull0, pull1) keeper of value 0.
REQ-019 DRIVE exits to TURN when one of these holds: owner's last is high, owner's req drops, or the hold counter reaches HOLD_MAX-1.
REQ-020 The hold counter is 8 bits, clears on DRIVE entry and increments each DRIVE cycle.
REQ-021 TURN lasts exactly one cycle; grant is all zero and the bus is released.
REQ-022 TURN goes to DRIVE if any req is set, otherwise to IDLE.
REQ-023 A requester whose grant was cut by HOLD_MAX may win again only if no other req is set.
REQ-024 Grant latency is 1 cycle from req in IDLE, and 0 dead cycles other than the single TURN cycle between owners.
REQ-025 Every DRIVE cycle, bus is sampled and compared to wdata[owner]; any bit mismatch sets contention on the next edge.
REQ-026 Contention is not checked in the first DRIVE cycle after TURN (settling).
REQ-027 Contention clears only on reset.
REQ-028 Simultaneous last and HOLD_MAX expiry: one transition to TURN, with no double count.
REQ-029 req bits arriving during TURN are considered for the TURN-to-DRIVE decision on that same edge.

Reset
REQ-030 On rst_n low, the following take effect immediately regardless of clk: state=IDLE, grant=0, busy=0, contention=0, hold counter=0, round-robin pointer=N_REQ-1, bus released.
REQ-031 Reset asserted mid-DRIVE releases the bus in the same time step, without waiting for a clock edge.
REQ-032 After rst_n rises, the first grant is no earlier than the second rising edge.

Structure
REQ-033 Package bus_arb_pkg holds the state enum (IDLE, DRIVE, TURN), the default parameter constants and the keeper/driver strength choice.
REQ-034 One sub-module, rr_pick, contains the combinational round-robin winner search, taking (req, pointer) and returning a one-hot winner.
REQ-035 The tri-state driver and keeper are continuous assignments with explicit strengths in the top module.

Verification
REQ-036 After reset, req=4'b0101 with last held high -> grant 0001, TURN, then grant 0100, TURN, then grant 0001; bus carries the respective wdata slices.
REQ-037 req[2] held, last=0, HOLD_MAX=16, others idle -> 16 DRIVE cycles, 1 TURN cycle, then re-grant to requester 2.
REQ-038 Owner 1 driving 8'hA5 while the bench forces a supply0 on bit 0 -> contention=1 two edges later and stays 1.
REQ-039 rst_n pulsed low mid-DRIVE between clock edges -> grant=0 and bus=8'h00 (keeper value) before the next edge.
REQ-040 No req for 10 cycles -> state IDLE, bus=8'h00 at pull strength, busy=0.
REQ-041 req=4'b1111 with last always high -> grant order 0001, 0010, 0100, 1000, 0001, with exactly one TURN cycle between grants.
